uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of the baud divisor.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- val  input  1  producer holds a valid word on data.
- data  input  DATA_BITS  word to send, LSB first.
- rdy  output  1  engine can accept a word.
- baud_div  input  DIV_W  each bit lasts baud_div+1 clk cycles.
- parity_en  input  1  1 = append a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- stop2  input  1  0 = one stop bit, 1 = two stop bits.
- tx  output  1  serial line; idles high.
- busy  output  1  frame in progress.

Function
REQ-003 The block SHALL use states IDLE, START, DATA, PARITY, STOP.
REQ-004 The handshake SHALL complete when val && rdy on a rising edge; rdy SHALL be 1 only in IDLE.
REQ-005 On handshake the block SHALL capture data, baud_div, parity_en, parity_type and stop2; input changes after that edge SHALL NOT affect the frame in flight.
REQ-006 tx SHALL be a registered output; tx SHALL go 0 on the first cycle after the handshake edge, and START is entered on that edge.
REQ-007 A bit counter SHALL count 0..baud_div; a state or bit advance SHALL occur when the count equals the captured baud_div, and the count SHALL then wrap to 0.
REQ-008 baud_div = 0 SHALL give one-cycle bits; the all-ones divisor SHALL give 2^DIV_W cycles per bit with no overflow.
REQ-009 In DATA, tx SHALL carry data[0]..data[DATA_BITS-1] in order, one bit period each, tracked by a bit-index counter of width clog2(DATA_BITS).
REQ-010 After DATA, the block SHALL enter PARITY if parity is enabled, else STOP.
REQ-011 The parity bit SHALL be the XOR of the captured data for even parity, and its inverse for odd parity.
REQ-012 STOP SHALL drive tx = 1 for 1 or 2 bit periods per the captured stop2, then enter IDLE.
REQ-013 Frame length SHALL be (1 + DATA_BITS + P + S)*(baud_div+1) cycles, where P = parity bits and S = stop bits.
REQ-014 The block SHALL spend exactly one IDLE cycle (tx = 1, rdy = 1) between frames; val held high SHALL start the next frame on that cycle.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 val while rdy = 0 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-017 While reset is high: state = IDLE, tx = 1, rdy = 1, busy = 0, all counters and captured registers = 0.
REQ-018 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously force tx = 1); the first frame after release SHALL be a full, correct frame.

Configuration
REQ-019 Macro UART_TX_PARITY_EN: when defined, parity logic and the PARITY state SHALL be present and follow REQ-010/011.
REQ-020 When UART_TX_PARITY_EN is undefined, parity_en and parity_type SHALL be present but ignored, and PARITY SHALL be unreachable; frames SHALL never carry a parity bit.

Verification
REQ-021 DATA_BITS = 8, baud_div = 3, data = 0xA5, no parity, one stop bit -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; rdy returns after 40 cycles.
REQ-022 data = 0x07, parity_en = 1, parity_type = 0, stop2 = 1 -> parity bit = 1, two stop periods, 12 bit periods total; repeat with parity_type = 1 -> parity bit = 0.
REQ-023 val held high with 0x55 then 0xAA, baud_div = 0 -> exactly one idle-high cycle between frames; both frames bit-exact.
REQ-024 Change baud_div, stop2 and data mid-frame -> the frame in flight is unchanged; the new values apply only to the next accepted frame.
REQ-025 Assert reset during DATA bit 4 -> tx = 1 and rdy = 1 asynchronously; the next frame after release is correct.
REQ-026 Build without UART_TX_PARITY_EN, parity_en = 1 -> frame length is 10 bit periods (DATA_BITS = 8, one stop bit) and no parity bit appears.

Source files
------------

// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine_if
// Description : Word handshake between a producer and the UART transmit
//               engine. The producer (master) drives val/data and the engine
//               (slave) answers with rdy.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_engine_if #(
  parameter int DATA_BITS = 8
);
  logic                 val;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;

  modport master (output val, output data, input rdy);
  modport slave  (input val, input data, output rdy);
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_engine
// Description : UART transmitter. Accepts a word on a val/rdy handshake and
//               sends start bit, DATA_BITS data bits LSB first, an optional
//               parity bit and one or two stop bits. Every bit lasts
//               baud_div+1 clk cycles. All frame settings are captured at the
//               handshake edge.
//               Build option: define UART_TX_PARITY_EN to include the parity
//               bit logic; without it parity_en/parity_type are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  uart_tx_engine_if.slave       bus,
  input  wire logic [DIV_W-1:0] baud_div,
  input  wire logic             parity_en,
  input  wire logic             parity_type,
  input  wire logic             stop2,
  output logic                  tx,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_W-1:0] C_CNT_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 stop2_q, stop2_d;
  logic                 tx_q, tx_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;

  logic                 w_bit_end;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_par_en;
  logic                 w_par_bit;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;

  assign w_par_en  = par_en_q;
  // Even parity is the XOR of the data bits; odd parity is its inverse.
  assign w_par_bit = (^data_q) ^ par_odd_q;
`else
  logic w_unused_parity;

  // Parity inputs exist on the port list but never influence a frame.
  assign w_unused_parity = parity_en ^ parity_type;
  assign w_par_en        = 1'b0;
  assign w_par_bit       = 1'b1;
`endif

  assign w_bit_end  = (cnt_q == div_q);
  assign w_idx_next = idx_q + IDX_W'(1);

  // Next-state, counters, capture registers and the next tx level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    div_d      = div_q;
    stop2_d    = stop2_q;
    tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.val && rdy_q) begin
          state_d    = START;
          tx_d       = 1'b0;
          cnt_d      = '0;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          data_d     = bus.data;
          div_d      = baud_div;
          stop2_d    = stop2;
`ifdef UART_TX_PARITY_EN
          par_en_d   = parity_en;
          par_odd_d  = parity_type;
`endif
        end
      end
      START: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (idx_q == C_LAST_IDX) begin
            if (w_par_en) begin
              state_d = PARITY;
              tx_d    = w_par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = w_idx_next;
            tx_d  = data_q[w_idx_next];
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (w_bit_end) begin
          cnt_d = '0;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame and idles the line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      data_q     <= '0;
      div_q      <= '0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      rdy_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      div_q      <= div_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign bus.rdy = rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_engine
// Description : Self-checking bench for uart_tx_engine (DATA_BITS=8,
//               DIV_W=16). Frame vectors carry hand-computed frame lengths
//               and parity bits; tx is checked every cycle of each frame.
//               Expectations follow the UART_TX_PARITY_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    bit          pe;
    bit          pt;
    bit          s2;
    int          periods;
    bit          par;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_type;
  logic        stop2;
  logic        tx;
  logic        busy;

  int n_checks;
  int n_fail;

  uart_tx_engine_if #(.DATA_BITS(8)) bus_if ();

  uart_tx_engine #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if.slave),
    .baud_div    (baud_div),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .stop2       (stop2),
    .tx          (tx),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge with the engine idle. Sends one frame and
  // checks it cycle by cycle; returns just after the edge that re-enters idle.
  task automatic do_frame(input vec_t v, input bit keep_val, input logic [7:0] next_data);
    logic lv[16];
    int   n;
    int   bp;
    int   len;
    for (int i = 0; i < 16; i++) lv[i] = 1'b1;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = v.data[i];
    n = 9;
    if (PAR_ON && v.pe) lv[n] = v.par;
    bp  = int'(v.div) + 1;
    len = v.periods * bp;
    bus_if.data = v.data;
    baud_div    = v.div;
    parity_en   = v.pe;
    parity_type = v.pt;
    stop2       = v.s2;
    bus_if.val  = 1'b1;
    @(posedge clk); #1;
    if (keep_val) begin
      bus_if.data = next_data;
    end else begin
      bus_if.val  = 1'b0;
      bus_if.data = ~v.data;
      baud_div    = v.div + 16'd3;
      stop2       = ~v.s2;
      parity_type = ~v.pt;
      parity_en   = ~v.pe;
    end
    for (int k = 0; k < len; k++) begin
      if (!keep_val && k == 2) bus_if.val = 1'b1;
      if (!keep_val && k == 3) bus_if.val = 1'b0;
      check("tx_bit", tx, lv[k / bp]);
      check("busy_in_frame", busy, 1'b1);
      check("rdy_in_frame", bus_if.rdy, 1'b0);
      @(posedge clk); #1;
    end
    check("idle_tx", tx, 1'b1);
    check("idle_rdy", bus_if.rdy, 1'b1);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v23a;
    vec_t v23b;
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    bus_if.val  = 1'b0;
    bus_if.data = '0;
    baud_div    = '0;
    parity_en   = 1'b0;
    parity_type = 1'b0;
    stop2       = 1'b0;

    // data, div, pe, pt, s2, bit periods, parity bit
    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 10, 1'b0};
    vecs[1] = '{8'h07, 16'd1, 1'b1, 1'b0, 1'b1, PAR_ON ? 12 : 11, 1'b1};
    vecs[2] = '{8'h07, 16'd1, 1'b1, 1'b1, 1'b1, PAR_ON ? 12 : 11, 1'b0};
    vecs[3] = '{8'h00, 16'd0, 1'b1, 1'b0, 1'b0, PAR_ON ? 11 : 10, 1'b0};
    vecs[4] = '{8'hFF, 16'd2, 1'b1, 1'b1, 1'b0, PAR_ON ? 11 : 10, 1'b1};
    vecs[5] = '{8'h3C, 16'd0, 1'b0, 1'b0, 1'b1, 11, 1'b0};
    v23a    = '{8'h55, 16'd0, 1'b0, 1'b0, 1'b0, 10, 1'b0};
    v23b    = '{8'hAA, 16'd0, 1'b0, 1'b0, 1'b0, 10, 1'b0};

    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_rdy", bus_if.rdy, 1'b1);
    check("reset_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) do_frame(vecs[i], 1'b0, 8'h00);

    // No frame may start from the val pulse seen while busy.
    for (int i = 0; i < 3; i++) begin
      check("no_queue_tx", tx, 1'b1);
      check("no_queue_rdy", bus_if.rdy, 1'b1);
      @(posedge clk); #1;
    end

    // Back-to-back frames with val held high.
    do_frame(v23a, 1'b1, 8'hAA);
    do_frame(v23b, 1'b0, 8'h00);

    // Reset during data bit 4 of 0xA5 (bit 4 is 0, so the line is low).
    bus_if.data = 8'hA5;
    baud_div    = 16'd3;
    parity_en   = 1'b0;
    stop2       = 1'b0;
    bus_if.val  = 1'b1;
    @(posedge clk); #1;
    bus_if.val  = 1'b0;
    repeat (21) begin
      @(posedge clk); #1;
    end
    check("pre_reset_tx", tx, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", tx, 1'b1);
    check("async_reset_rdy", bus_if.rdy, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    do_frame(vecs[0], 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
